// File: rtl/pio_irq_service_master_pkg.sv
// Shared definitions for the PIO irq service master and its PIO slave bench.
//   - Register addresses of the 1-bit edge-capture PIO slave.
//   - FSM state encoding of the service master.
package pio_irq_service_master_pkg;

    localparam logic [2:0] PIO_ADDR_DATA   = 3'd0;
    localparam logic [2:0] PIO_ADDR_MASK   = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE   = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR = 3'd5;

    typedef enum logic [3:0] {
        ST_ARM     = 4'd0,
        ST_IDLE    = 4'd1,
        ST_RD_EC   = 4'd2,
        ST_WT_EC   = 4'd3,
        ST_CLR_EC  = 4'd4,
        ST_SPUR    = 4'd5,
        ST_RD_DAT  = 4'd6,
        ST_WT_DAT  = 4'd7,
        ST_SET_ACK = 4'd8,
        ST_HOLD    = 4'd9,
        ST_CLR_ACK = 4'd10
    } svc_state_e;

endpackage

// File: rtl/pio_irq_service_master.sv
// Avalon-MM master servicing a 1-bit edge-capture PIO slave on its irq line.
// After reset it arms the slave irq mask; on every irq it reads and clears
// edgecapture, reads the input level, reports the event and handshakes back
// through out_port with a set write, ACK_HOLD cycles of hold, and a clear write.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   irq                   slave irq (level)
//   readdata[31:0]        slave readdata, valid the cycle after a read command
//   address[2:0]          slave register address
//   chipselect, write_n   one-cycle bus command strobes
//   writedata[31:0]       slave write data
//   evt_valid, evt_level  one-cycle event pulse and the level read for it
//   evt_count, spur_count genuine / spurious irq counters (wrapping)
//   busy                  high whenever the FSM is not in IDLE
module pio_irq_service_master
    import pio_irq_service_master_pkg::*;
#(
    parameter int ACK_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic [31:0]      readdata,
    output logic [2:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    output logic             evt_valid,
    output logic             evt_level,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] spur_count,
    output logic             busy
);

    // Hold counter only ever holds ACK_HOLD-1 down to 0.
    localparam int HOLD_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ACK_HOLD - 1);

    svc_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ec_q, ec_d;
    logic              evt_level_q, evt_level_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CNT_W-1:0]  evt_count_q, evt_count_d;
    logic [CNT_W-1:0]  spur_count_q, spur_count_d;

    logic              cmd_cs;
    logic              cmd_wn;
    logic [2:0]        cmd_addr;
    logic [31:0]       cmd_wd;

    // Only bit 0 of the slave is meaningful.
    logic              rd_unused;
    assign rd_unused = ^readdata[31:1];

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        ec_d         = ec_q;
        evt_level_d  = evt_level_q;
        evt_valid_d  = 1'b0;
        evt_count_d  = evt_count_q;
        spur_count_d = spur_count_q;
        cmd_cs       = 1'b0;
        cmd_wn       = 1'b1;
        cmd_addr     = PIO_ADDR_DATA;
        cmd_wd       = 32'd0;

        case (state_q)
            ST_ARM: begin
                cmd_cs   = 1'b1;
                cmd_wn   = 1'b0;
                cmd_addr = PIO_ADDR_MASK;
                cmd_wd   = 32'd1;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (irq) state_d = ST_RD_EC;
            end
            ST_RD_EC: begin
                cmd_cs   = 1'b1;
                cmd_addr = PIO_ADDR_EDGE;
                state_d  = ST_WT_EC;
            end
            ST_WT_EC: begin
                ec_d    = readdata[0];
                state_d = ST_CLR_EC;
            end
            ST_CLR_EC: begin
                // Any write clears edgecapture; an edge landing after this
                // write re-raises irq and is picked up from IDLE later.
                cmd_cs   = 1'b1;
                cmd_wn   = 1'b0;
                cmd_addr = PIO_ADDR_EDGE;
                state_d  = ec_q ? ST_RD_DAT : ST_SPUR;
            end
            ST_SPUR: begin
                spur_count_d = spur_count_q + 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RD_DAT: begin
                cmd_cs   = 1'b1;
                cmd_addr = PIO_ADDR_DATA;
                state_d  = ST_WT_DAT;
            end
            ST_WT_DAT: begin
                evt_level_d = readdata[0];
                evt_valid_d = 1'b1;
                evt_count_d = evt_count_q + 1'b1;
                state_d     = ST_SET_ACK;
            end
            ST_SET_ACK: begin
                cmd_cs   = 1'b1;
                cmd_wn   = 1'b0;
                cmd_addr = PIO_ADDR_OUTSET;
                cmd_wd   = 32'd1;
                hold_d   = HOLD_LOAD;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == '0) state_d = ST_CLR_ACK;
                else              hold_d  = hold_q - 1'b1;
            end
            ST_CLR_ACK: begin
                cmd_cs   = 1'b1;
                cmd_wn   = 1'b0;
                cmd_addr = PIO_ADDR_OUTCLR;
                cmd_wd   = 32'd1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARM;
            hold_q       <= '0;
            ec_q         <= 1'b0;
            evt_level_q  <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_count_q  <= '0;
            spur_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            ec_q         <= ec_d;
            evt_level_q  <= evt_level_d;
            evt_valid_q  <= evt_valid_d;
            evt_count_q  <= evt_count_d;
            spur_count_q <= spur_count_d;
        end
    end

    // The bus is held idle while reset is asserted so the ARM write is issued
    // exactly once, in the first cycle after reset is released.
    assign chipselect = cmd_cs & ~reset;
    assign write_n    = cmd_wn | reset;
    assign address    = reset ? 3'd0 : cmd_addr;
    assign writedata  = reset ? 32'd0 : cmd_wd;

    assign evt_valid  = evt_valid_q;
    assign evt_level  = evt_level_q;
    assign evt_count  = evt_count_q;
    assign spur_count = spur_count_q;
    assign busy       = reset | (state_q != ST_IDLE);

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Bench for pio_irq_service_master: instance 0 with default parameters,
// instance 1 with ACK_HOLD=1, CNT_W=4, each attached to a PIO slave model.
module tb_pio_irq_service_master;
    import pio_irq_service_master_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             mdl_rst;
    logic [1:0]       s_cs, s_wn, s_valid, s_level, s_busy;
    logic [1:0][2:0]  s_addr;
    logic [1:0][31:0] s_wd, s_rd;
    logic [15:0]      cnt_a, spur_a;
    logic [3:0]       cnt_b, spur_b;

    // PIO slave model state
    logic [1:0] in_port, in_d, mask, ec, out_port, force_irq, irq, wr, rd_en;
    int         cyc;
    int         set_cyc[2], clr_cyc[2], n_outset[2], n_outclr[2], n_valid[2];

    int n_checks = 0;
    int n_errors = 0;

    pio_irq_service_master #(.ACK_HOLD(16), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(rst), .irq(irq[0]), .readdata(s_rd[0]),
        .address(s_addr[0]), .chipselect(s_cs[0]), .write_n(s_wn[0]),
        .writedata(s_wd[0]), .evt_valid(s_valid[0]), .evt_level(s_level[0]),
        .evt_count(cnt_a), .spur_count(spur_a), .busy(s_busy[0])
    );

    pio_irq_service_master #(.ACK_HOLD(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(rst), .irq(irq[1]), .readdata(s_rd[1]),
        .address(s_addr[1]), .chipselect(s_cs[1]), .write_n(s_wn[1]),
        .writedata(s_wd[1]), .evt_valid(s_valid[1]), .evt_level(s_level[1]),
        .evt_count(cnt_b), .spur_count(spur_b), .busy(s_busy[1])
    );

    assign wr    = s_cs & ~s_wn;
    assign rd_en = s_cs & s_wn;
    assign irq   = (ec & mask) | force_irq;

    // Slave: falling-edge capture, registered readdata, any write to EDGE
    // clears it (an edge in the same cycle as the clear survives).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mdl_rst) begin
            in_d     <= in_port;
            mask     <= '0;
            ec       <= '0;
            out_port <= '0;
            s_rd     <= '0;
            cyc      <= 0;
            for (int i = 0; i < 2; i++) begin
                set_cyc[i]  <= 0;
                clr_cyc[i]  <= 0;
                n_outset[i] <= 0;
                n_outclr[i] <= 0;
                n_valid[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                in_d[i] <= in_port[i];
                ec[i]   <= (in_d[i] & ~in_port[i]) |
                           (ec[i] & ~(wr[i] && s_addr[i] == PIO_ADDR_EDGE));
                if (rd_en[i]) begin
                    case (s_addr[i])
                        PIO_ADDR_DATA: s_rd[i] <= {31'd0, in_port[i]};
                        PIO_ADDR_MASK: s_rd[i] <= {31'd0, mask[i]};
                        PIO_ADDR_EDGE: s_rd[i] <= {31'd0, ec[i]};
                        default:       s_rd[i] <= 32'd0;
                    endcase
                end
                if (wr[i] && s_addr[i] == PIO_ADDR_MASK) mask[i] <= s_wd[i][0];
                if (wr[i] && s_addr[i] == PIO_ADDR_OUTSET) begin
                    if (s_wd[i][0]) out_port[i] <= 1'b1;
                    set_cyc[i]  <= cyc;
                    n_outset[i] <= n_outset[i] + 1;
                end
                if (wr[i] && s_addr[i] == PIO_ADDR_OUTCLR) begin
                    if (s_wd[i][0]) out_port[i] <= 1'b0;
                    clr_cyc[i]  <= cyc;
                    n_outclr[i] <= n_outclr[i] + 1;
                end
                if (s_valid[i]) n_valid[i] <= n_valid[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input string tag, input int i, input logic cs, input logic wn,
                              input logic [2:0] addr, input logic [31:0] wd);
        chk({tag, "_cs"},   s_cs[i],   cs);
        chk({tag, "_wn"},   s_wn[i],   wn);
        chk({tag, "_addr"}, s_addr[i], addr);
        chk({tag, "_wd"},   s_wd[i],   wd);
    endtask

    task automatic wait_idle(input string tag, input int i, input int limit);
        int n = 0;
        while ((s_busy[i] || irq[i]) && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, s_busy[i] | irq[i], 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        mdl_rst   = 1'b1;
        in_port   = 2'b11;
        force_irq = 2'b00;

        // 1: reset values, then the ARM write, then an idle bus
        repeat (3) tick();
        expect_cmd("t1_rst", 0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("t1_rst_valid", s_valid, 2'b00);
        chk("t1_rst_level", s_level, 2'b00);
        chk("t1_rst_cnt", cnt_a, 0);
        chk("t1_rst_spur", spur_a, 0);
        chk("t1_rst_cnt_b", cnt_b, 0);
        chk("t1_rst_busy", s_busy, 2'b11);
        rst     = 1'b0;
        mdl_rst = 1'b0;
        #1;
        expect_cmd("t1_arm_a", 0, 1'b1, 1'b0, PIO_ADDR_MASK, 32'd1);
        expect_cmd("t1_arm_b", 1, 1'b1, 1'b0, PIO_ADDR_MASK, 32'd1);
        tick();
        expect_cmd("t1_idle", 0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("t1_mask", mask, 2'b11);
        chk("t1_busy", s_busy, 2'b00);

        // 2: one falling edge at level 0, cycle by cycle
        in_port[0] = 1'b0;
        tick();
        chk("t2_irq", irq[0], 1'b1);
        tick();
        expect_cmd("t2_rd_ec", 0, 1'b1, 1'b1, PIO_ADDR_EDGE, 32'd0);
        tick();
        expect_cmd("t2_wt_ec", 0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("t2_ec_rd", s_rd[0], 32'd1);
        tick();
        expect_cmd("t2_clr_ec", 0, 1'b1, 1'b0, PIO_ADDR_EDGE, 32'd0);
        tick();
        expect_cmd("t2_rd_dat", 0, 1'b1, 1'b1, PIO_ADDR_DATA, 32'd0);
        chk("t2_irq_clr", irq[0], 1'b0);
        tick();
        chk("t2_pre_valid", s_valid[0], 1'b0);
        tick();
        expect_cmd("t2_set_ack", 0, 1'b1, 1'b0, PIO_ADDR_OUTSET, 32'd1);
        chk("t2_valid", s_valid[0], 1'b1);
        chk("t2_level", s_level[0], 1'b0);
        chk("t2_cnt", cnt_a, 1);
        tick();
        chk("t2_valid_off", s_valid[0], 1'b0);
        chk("t2_out_set", out_port[0], 1'b1);
        repeat (15) tick();
        chk("t2_hold_bus", s_cs[0], 1'b0);
        chk("t2_out_hold", out_port[0], 1'b1);
        tick();
        expect_cmd("t2_clr_ack", 0, 1'b1, 1'b0, PIO_ADDR_OUTCLR, 32'd1);
        tick();
        chk("t2_out_clr", out_port[0], 1'b0);
        chk("t2_busy", s_busy[0], 1'b0);
        // SET_ACK, 16 HOLD cycles, CLR_ACK
        chk("t2_hold_gap", clr_cyc[0] - set_cyc[0], 17);

        // 3: spurious irq with edgecapture = 0
        force_irq[0] = 1'b1;
        tick();
        force_irq[0] = 1'b0;
        wait_idle("t3", 0, 20);
        chk("t3_spur", spur_a, 1);
        chk("t3_cnt", cnt_a, 1);
        chk("t3_no_outset", n_outset[0], 1);
        chk("t3_no_valid", n_valid[0], 1);

        // 4a: level 1 event, then a second edge arriving during HOLD
        in_port[0] = 1'b1;
        tick();
        in_port[0] = 1'b0;
        tick();
        tick();
        in_port[0] = 1'b1;
        for (int n = 0; n < 30 && !out_port[0]; n++) tick();
        chk("t4a_out_set", out_port[0], 1'b1);
        chk("t4a_level1", s_level[0], 1'b1);
        chk("t4a_cnt1", cnt_a, 2);
        tick();
        tick();
        in_port[0] = 1'b0;
        tick();
        tick();
        chk("t4a_busy_hold", s_busy[0], 1'b1);
        wait_idle("t4a", 0, 60);
        chk("t4a_cnt2", cnt_a, 3);
        chk("t4a_level0", s_level[0], 1'b0);
        chk("t4a_valid", n_valid[0], 3);
        chk("t4a_spur", spur_a, 1);
        chk("t4a_out", out_port[0], 1'b0);

        // 4b: a second edge before CLR_EC merges into the same event
        in_port[0] = 1'b1;
        tick();
        in_port[0] = 1'b0;
        tick();
        in_port[0] = 1'b1;
        tick();
        in_port[0] = 1'b0;
        tick();
        wait_idle("t4b", 0, 60);
        chk("t4b_cnt", cnt_a, 4);
        chk("t4b_valid", n_valid[0], 4);
        chk("t4b_spur", spur_a, 1);

        // 5: reset while HOLD counter is at 8
        in_port[0] = 1'b1;
        tick();
        in_port[0] = 1'b0;
        for (int n = 0; n < 30 && !(wr[0] && s_addr[0] == PIO_ADDR_OUTSET); n++) tick();
        chk("t5_set_seen", wr[0] && s_addr[0] == PIO_ADDR_OUTSET, 1'b1);
        chk("t5_cnt_pre", cnt_a, 5);
        tick();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        expect_cmd("t5_rst", 0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("t5_cnt", cnt_a, 0);
        chk("t5_spur", spur_a, 0);
        chk("t5_valid", s_valid[0], 1'b0);
        chk("t5_level", s_level[0], 1'b0);
        chk("t5_busy", s_busy[0], 1'b1);
        chk("t5_no_clr", n_outclr[0], 4);
        rst = 1'b0;
        in_port[0] = 1'b1;
        #1;
        expect_cmd("t5_arm", 0, 1'b1, 1'b0, PIO_ADDR_MASK, 32'd1);
        tick();
        chk("t5_out_kept", out_port[0], 1'b1);
        chk("t5_idle", s_busy[0], 1'b0);

        // 6: CNT_W=4 wrap after 16 events, ACK_HOLD=1
        for (int k = 1; k <= 16; k++) begin
            in_port[1] = 1'b0;
            tick();
            tick();
            tick();
            in_port[1] = 1'b1;
            wait_idle("t6", 1, 40);
            if (k == 1) chk("t6_hold_gap", clr_cyc[1] - set_cyc[1], 2);
            if (k == 15) chk("t6_cnt15", cnt_b, 15);
        end
        chk("t6_wrap", cnt_b, 0);
        chk("t6_valid", n_valid[1], 16);
        chk("t6_level", s_level[1], 1'b1);
        chk("t6_spur", spur_b, 0);
        chk("t6_out", out_port[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
